// File: rtl/spram_pkg.sv
// Shared constants and types for the 64 x 8 single-port RAM.
package spram_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    // Every address maps to a word, so no range check is needed anywhere.
    localparam int DEPTH  = 2**ADDR_W;

    typedef logic [DATA_W-1:0] spram_data_t;
    typedef logic [ADDR_W-1:0] spram_addr_t;

endpackage

// File: rtl/spram_clear_ctrl.sv
// Post-reset clear sweep for single_port_ram: walks a counter over every
// address, one per clock, and holds busy high until the last word is zeroed.
// The whole module exists only when SPRAM_CLEAR_EN is defined.
`ifdef SPRAM_CLEAR_EN
module spram_clear_ctrl
    import spram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        busy,
    output spram_addr_t clr_addr
);

    // Counter and busy flag; reset restarts the sweep at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (busy) begin
            clr_addr <= clr_addr + 1'b1;
            // The edge that clears the last word also ends the sweep.
            if (clr_addr == spram_addr_t'(DEPTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/single_port_ram.sv
// 64 x 8 synchronous single-port RAM, shared address, registered read data,
// write-first. Reset clears only the output register, never the array.
// Build option SPRAM_CLEAR_EN adds a busy output and a post-reset sweep that
// zeroes every word before normal access is allowed.
module single_port_ram
    import spram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  spram_data_t data,
    input  spram_addr_t addr,
`ifdef SPRAM_CLEAR_EN
    output logic        busy,
`endif
    output spram_data_t q
);

    spram_data_t mem [DEPTH];

`ifdef SPRAM_CLEAR_EN
    spram_addr_t clr_addr;

    spram_clear_ctrl u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_addr (clr_addr)
    );
`endif

    // Array write and output register share one block: the reset branch
    // only clears q, and because the array is touched solely in the
    // non-reset branch, writes presented while rst_n is low are dropped
    // without feeding rst_n into any data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
`ifdef SPRAM_CLEAR_EN
            if (busy) begin
                mem[clr_addr] <= '0;
                q             <= '0;
            end else
`endif
            if (we) begin
                mem[addr] <= data;
                q         <= data;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: reset checks, a vector table of
// accesses with fixed expectations, hand-written hold/async-reset sequences,
// and a randomized phase predicted by a small memory model.
module tb_single_port_ram;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [7:0] data;
    logic [5:0] addr;
    logic [7:0] q;
`ifdef SPRAM_CLEAR_EN
    logic       busy;
`endif

    single_port_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .data  (data),
        .addr  (addr),
`ifdef SPRAM_CLEAR_EN
        .busy  (busy),
`endif
        .q     (q)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model [64];
    bit         known [64];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // One access per clock: inputs change on the falling edge, q is sampled
    // 1 ns after the rising edge that performs the access.
    task automatic do_access(input string name, input logic w, input logic [5:0] a,
                             input logic [7:0] d, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk);
        we   = w;
        addr = a;
        data = d;
        exp_q.push_back(exp);
        if (w) begin
            model[a] = d;
            known[a] = 1'b1;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, q, e);
    endtask

`ifdef SPRAM_CLEAR_EN
    // After a reset: busy must stay high through the sweep, q held at 0.
    task automatic check_sweep(input string name);
        check({name, "_busy_start"}, {7'b0, busy}, 8'h01);
        for (int i = 0; i < 63; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || q !== 8'h00) begin
                check({name, "_busy_mid"}, {busy, q[6:0]}, 8'h80);
            end
        end
        check({name, "_q_during_sweep"}, q, 8'h00);
        @(posedge clk);
        #1;
        check({name, "_busy_end"}, {7'b0, busy}, 8'h00);
        for (int i = 0; i < 64; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b1;
        end
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] e;

        vecs[0]  = '{1'b1, 6'd5,  8'hAA, 8'hAA};
        vecs[1]  = '{1'b1, 6'd25, 8'h55, 8'h55};
        vecs[2]  = '{1'b1, 6'd55, 8'h45, 8'h45};
        vecs[3]  = '{1'b0, 6'd5,  8'h00, 8'hAA};
        vecs[4]  = '{1'b0, 6'd25, 8'h11, 8'h55};
        vecs[5]  = '{1'b0, 6'd55, 8'h22, 8'h45};
        vecs[6]  = '{1'b1, 6'd10, 8'h3C, 8'h3C};
        vecs[7]  = '{1'b0, 6'd10, 8'h00, 8'h3C};
        vecs[8]  = '{1'b1, 6'd63, 8'hFF, 8'hFF};
        vecs[9]  = '{1'b1, 6'd0,  8'h01, 8'h01};
        vecs[10] = '{1'b0, 6'd63, 8'h00, 8'hFF};
        vecs[11] = '{1'b0, 6'd0,  8'h00, 8'h01};

        for (int i = 0; i < 64; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b0;
        end

        // Reset: q is 0 and a write attempted under reset is dropped.
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 6'd0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_q", q, 8'h00);
        @(negedge clk);
        we   = 1'b1;
        addr = 6'd7;
        data = 8'h99;
        @(posedge clk);
        #1;
        check("reset_q_write", q, 8'h00);
        @(negedge clk);
        we    = 1'b0;
        addr  = 6'd0;
        rst_n = 1'b1;
`ifdef SPRAM_CLEAR_EN
        check_sweep("init");
`endif

        // Table-driven accesses.
        for (int i = 0; i < 12; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
        end

        // Hold: toggle every input between edges; q must not move.
        @(negedge clk);
        #1 addr = 6'd10;
        #1 addr = 6'd63; data = 8'h77;
        #1 we = 1'b1;
        #1 we = 1'b0;
        check("hold_between_edges", q, 8'h01);

        // Asynchronous reset mid-cycle; memory must survive it.
        do_access("reset_prewrite", 1'b1, 6'd25, 8'h55, 8'h55);
        #2 rst_n = 1'b0;
        #1 check("async_reset_drop", q, 8'h00);
        @(negedge clk);
        we   = 1'b1;
        addr = 6'd25;
        data = 8'hEE;
        @(posedge clk);
        #1;
        check("reset_hold_q", q, 8'h00);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
`ifdef SPRAM_CLEAR_EN
        check_sweep("rerst");
        do_access("reset_readback", 1'b0, 6'd25, 8'h00, 8'h00);
`else
        do_access("reset_readback", 1'b0, 6'd25, 8'h00, 8'h55);
`endif

        // Randomized accesses predicted by the model; reads only hit
        // locations whose content is defined.
        for (int i = 0; i < 48; i++) begin
            a = 6'($urandom_range(63));
            w = ($urandom_range(1) == 1) || !known[a];
            d = 8'($urandom_range(255));
            e = w ? d : model[a];
            do_access($sformatf("rand%0d", i), w, a, d, e);
        end

        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
